// File: rtl/psum_ofifo.sv
// Per-column partial-sum FIFOs that re-align skewed MAC columns
// into whole rows for a single downstream reader.
module psum_ofifo #(
  parameter int col     = 8,
  parameter int bw_psum = 22,
  parameter int depth   = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [col-1:0]              wr,
  input  logic [col*bw_psum-1:0]      in,
  input  logic                        rd,
  output logic [col*bw_psum-1:0]      out,
  output logic                        o_valid,
  output logic                        o_full,
  output logic [$clog2(depth):0]      o_rows,
  output logic                        o_err
);

  localparam int AW = $clog2(depth);

  logic [bw_psum-1:0] mem_q [col][depth];
  logic [AW:0]        wp_q  [col];
  logic [AW:0]        wp_d  [col];
  logic [AW:0]        rp_q  [col];
  logic [AW:0]        rp_d  [col];
  logic [AW:0]        occ   [col];
  logic [col-1:0]     full;
  logic [col-1:0]     empty;
  logic [col-1:0]     wr_ok;
  logic               rd_ok;
  logic               drop;
  logic               err_q;
  logic               err_d;

  always_comb begin
    for (int j = 0; j < col; j++) begin
      occ[j]   = wp_q[j] - rp_q[j];
      empty[j] = (wp_q[j] == rp_q[j]);
      full[j]  = (wp_q[j][AW-1:0] == rp_q[j][AW-1:0])
               && (wp_q[j][AW] != rp_q[j][AW]);
    end
  end

  assign o_valid = ~|empty;
  assign o_full  = |full;
  assign rd_ok   = rd & o_valid;

  // A pop in the same cycle frees the slot a full column writes into
  assign wr_ok = wr & (~full | {col{rd_ok}});
  assign drop  = |(wr & full & ~{col{rd_ok}});
  assign err_d = err_q | drop | (rd & ~o_valid);
  assign o_err = err_q;

  always_comb begin
    logic [AW:0] mn;
    mn = occ[0];
    for (int j = 1; j < col; j++) begin
      if (occ[j] < mn) mn = occ[j];
    end
    o_rows = mn;
  end

  always_comb begin
    for (int j = 0; j < col; j++) begin
      wp_d[j] = wp_q[j] + {{AW{1'b0}}, wr_ok[j]};
      rp_d[j] = rp_q[j] + {{AW{1'b0}}, rd_ok};
    end
  end

  always_comb begin
    out = '0;
    for (int j = 0; j < col; j++) begin
      if (o_valid)
        out[j*bw_psum +: bw_psum] = mem_q[j][rp_q[j][AW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < col; j++) begin
        wp_q[j] <= '0;
        rp_q[j] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int j = 0; j < col; j++) begin
        wp_q[j] <= wp_d[j];
        rp_q[j] <= rp_d[j];
      end
      err_q <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < col; j++) begin
      if (wr_ok[j])
        mem_q[j][wp_q[j][AW-1:0]] <= in[j*bw_psum +: bw_psum];
    end
  end

endmodule

// File: doc/psum_ofifo.md
# psum_ofifo

Output collector for the MAC column array: one small FIFO per column absorbs each column's partial sum on its `fifo_wr` strobe, whatever the column-to-column skew. Each FIFO holds a `bw_psum`-bit word. The block presents one complete row (one psum per column) once every column has data. A downstream reader (SRAM writeback or normalizer) pops whole rows with `rd`.

## Interface
- `col`, default 8: number of MAC columns feeding the collector.
- `bw_psum`, default 22: psum width. This equals 2*bw+6 for bw=8.
- `depth`, default 16: entries per column FIFO. Must be a power of 2 and at least 2.
- `clk` input, 1 bit: single clock. All state updates on the rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `wr` input, `col` bits: per-column write strobe. Bit j is driven by column j's `fifo_wr`.
- `in` input, `col*bw_psum` bits: column psums. Column j is at `[j*bw_psum +: bw_psum]`, and its value is sampled when `wr[j]` is high.
- `rd` input, 1 bit: pop the head row.
- `out` output, `col*bw_psum` bits: head row, with the same column packing as `in`. Reads 0 when `o_valid` is low.
- `o_valid` output, 1 bit: every column FIFO is non-empty.
- `o_full` output, 1 bit: at least one column FIFO is full.
- `o_rows` output, log2(depth)+1 bits: number of complete rows, i.e. the minimum occupancy over all columns.
- `o_err` output, 1 bit: sticky error flag. Set on a dropped write or an illegal read; cleared only by reset.

## Operation
- Per column j: storage `mem_j[depth]`, plus write pointer `wp_j` and read pointer `rp_j`.
  - Each pointer is log2(depth)+1 bits, with the MSB acting as the wrap bit.
  - occupancy_j = wp_j - rp_j, computed modulo 2^(log2(depth)+1).
  - empty_j is true when wp_j == rp_j.
  - full_j is true when the low bits are equal and the wrap bits differ.
- Derived flags:
  - `o_valid` is the AND of all ~empty_j.
  - `o_full` is the OR of all full_j.
  - `o_rows` is the minimum occupancy_j over all columns.
- Read: a read is accepted when `rd` and `o_valid` are both high. All `rp_j` advance together by 1.
- Illegal read: `rd` while `o_valid` is low leaves the pointers unchanged and sets `o_err`.
- Write to column j: accepted when `wr[j]` is high and (~full_j, or a read is accepted in the same cycle). On acceptance:
  - `mem_j[wp_j]` is written with `in[j]`.
  - `wp_j` increments.
- Dropped write: `wr[j]` high on a full column with no accepted read that cycle. The data is discarded, `wp_j` is unchanged, and `o_err` is set.
- Simultaneous read and write on the same column: both are applied and occupancy_j is unchanged. This holds at full, and at occupancy 1 when all other columns make `o_valid` true.
- Simultaneous write on an empty column: the new word is not visible to a read in that same cycle.
- Columns are independent. Any subset of `wr` bits may be high in a cycle, so skewed columns fill at different times.
- Pointer wrap: low bits wrap from depth-1 to 0 and the wrap bit toggles. No other special handling.
- `out[j]` is `mem_j[rp_j low bits]`, combinational from the stored array, gated to 0 when `o_valid` is low.

## Timing
- Reset value of every output while `reset` is low, asynchronously:
  - `out` = 0
  - `o_valid` = 0
  - `o_full` = 0
  - `o_rows` = 0
  - `o_err` = 0
- Reset clears all pointers. Memory contents are not reset.
- Reset asserted mid-operation discards all buffered rows immediately. The block is writable on the first rising edge after reset deasserts.
- Write-to-visibility latency: a write sampled at edge k makes the flags reflect it after edge k.
  - If that write completes a row, `o_valid` and `out` are valid in cycle k+1.
  - No extra pipeline stage.
- Read: the pop happens at the edge where `rd` and `o_valid` are both high. `out` shows the next row, or 0, after that edge.
- Back-to-back reads are allowed every cycle while `o_valid` stays high. Sustained throughput is one row per cycle.
- `rd` is meaningful only as a single-cycle sample. It is not a request/grant handshake.

## Test plan
- Reset behaviour:
  - Stimulus: pulse `reset` low mid-cycle with 3 rows buffered.
  - Response: all outputs are 0 immediately. After release, `o_rows`=0 and `o_valid`=0.
- Skewed fill (col=8, bw_psum=22):
  - Stimulus: column j writes value 100+j at cycle 2+j.
  - Response: `o_valid` stays 0 until after cycle 9. Then `out[j]`=100+j and `o_rows`=1. `rd`=1 returns `o_valid`=0.
- Full and overflow:
  - Stimulus: write 16 rows with no reads.
  - Response: `o_full`=1 and `o_rows`=16. A 17th `wr[3]` sets `o_err`=1, and `o_rows` stays 16.
  - Stimulus: drain all 16 rows.
  - Response: 16 rows in order, head value 0..15 per column.
- Read and write together at full:
  - Stimulus: at full, assert `rd` and `wr`=all ones with value 16.
  - Response: `o_rows` stays 16, `o_err` stays 0, and the 16th popped row holds 16.
- Wrap-around:
  - Stimulus: stream 40 rows with simultaneous `rd`, where each row's value is its index.
  - Response: outputs arrive in exact sequence 0..39, `o_rows` is at most 1, and `o_err`=0.
- Illegal read:
  - Stimulus: `rd`=1 while empty, or with 7 of 8 columns filled.
  - Response: pointers are unchanged, `o_err`=1, and `o_err` stays 1 until reset.
